// File: rtl/ct_tdma_gate_sched_pkg.sv
// Shared constants and types for the constant-time TDMA gate scheduler.
// Phase constants name the cycles of a slot; owner_t sizes the owner index.
package ct_sched_pkg;
  localparam int DEF_W        = 8;
  localparam int DEF_N_REQ    = 2;
  localparam int DEF_SLOT_LEN = 4;

  localparam int PH_SAMPLE = 0;
  localparam int PH_GATE   = 1;
  localparam int PH_EMIT   = 2;

  localparam int OWNER_W = (DEF_N_REQ > 1) ? $clog2(DEF_N_REQ) : 1;
  typedef logic [OWNER_W-1:0] owner_t;
endpackage

// File: rtl/ct_tdma_gate_sched_mask_gate.sv
// Zero-or-pass masking gate: the control bit forces the data to zero.
module ct_mask_gate #(
  parameter int W = 8
) (
  input  logic         ct,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  assign y = ct ? '0 : x;
endmodule

// File: rtl/ct_tdma_gate_sched.sv
// Strict TDMA scheduler sharing one masking gate between N_REQ requesters.
// Optional macro CT_SCHED_SKIP_EN makes idle slots collapse to one cycle (not constant-time).
module ct_tdma_gate_sched
  import ct_sched_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int N_REQ    = DEF_N_REQ,
  parameter int SLOT_LEN = DEF_SLOT_LEN,
  localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW      = $clog2(SLOT_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ*W-1:0] in_data,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  output logic             out_live,
  output logic [IDW-1:0]   out_id,
  output logic [W-1:0]     out_data
);
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [IDW-1:0] owner_reg, owner_next;
  logic [W-1:0]   in_reg;
  logic           ct_reg;
  logic [IDW-1:0] id_reg;
  logic [W-1:0]   gate_y;
  logic [W-1:0]   lane [N_REQ];
  logic           is_sample, is_gate, owner_last, req_owner;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign lane[gi] = in_data[gi*W +: W];
      // Only the owner's request is looked at, and only in the sample cycle.
      assign gnt[gi]  = ~rst & is_sample & (owner_reg == IDW'(gi)) & req[gi];
    end
  endgenerate

  assign is_sample  = (cnt_reg == CW'(PH_SAMPLE));
  assign is_gate    = (cnt_reg == CW'(PH_GATE));
  assign owner_last = (owner_reg == IDW'(N_REQ - 1));
  assign req_owner  = req[owner_reg];

  always_comb begin
    cnt_next   = cnt_reg + CW'(1);
    owner_next = owner_reg;
    if (cnt_reg == CW'(SLOT_LEN - 1)) begin
      cnt_next   = '0;
      owner_next = owner_last ? '0 : owner_reg + IDW'(1);
    end
`ifdef CT_SCHED_SKIP_EN
    if (is_sample && !req_owner) begin
      cnt_next   = '0;
      owner_next = owner_last ? '0 : owner_reg + IDW'(1);
    end
`endif
  end

  ct_mask_gate #(.W(W)) u_gate (
    .ct (ct_reg),
    .x  (in_reg),
    .y  (gate_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      owner_reg <= '0;
      in_reg    <= '0;
      ct_reg    <= 1'b1;
      id_reg    <= '0;
      out_valid <= 1'b0;
      out_live  <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
    end else begin
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
      // Data is captured whether or not the owner requests, keeping activity data-independent.
      if (is_sample) begin
        in_reg <= lane[owner_reg];
        ct_reg <= ~req_owner;
        id_reg <= owner_reg;
      end
      out_valid <= is_gate;
      if (is_gate) begin
        out_data <= gate_y;
        out_live <= ~ct_reg;
        out_id   <= id_reg;
      end
    end
  end
endmodule

// File: tb/tb_ct_tdma_gate_sched.sv
// Self-checking bench for ct_tdma_gate_sched against a slot-level reference model.
module tb_ct_tdma_gate_sched;
  import ct_sched_pkg::*;

  localparam int W   = DEF_W;
  localparam int N   = DEF_N_REQ;
  localparam int SL  = DEF_SLOT_LEN;
  localparam int IDW = OWNER_W;

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic           valid;
    logic           live;
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } obs_t;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     gnt;
  logic             out_valid;
  logic             out_live;
  logic [IDW-1:0]   out_id;
  logic [W-1:0]     out_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: position within the slot schedule and the latest emitted result
  int             m_ph, m_slot;
  logic           m_live, p_live;
  logic [IDW-1:0] m_id, p_id;
  logic [W-1:0]   m_data, p_data;

  ct_tdma_gate_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in_data   (in_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_live  (out_live),
    .out_id    (out_id),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (out_valid)
      $display("emit t=%0t id=%0d live=%0b data=%02h", $time, out_id, out_live, out_data);

  function automatic obs_t observed();
    return {gnt, out_valid, out_live, out_id, out_data};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_slot = 0;
    m_live = 1'b0; m_id = '0; m_data = '0;
    p_live = 1'b0; p_id = '0; p_data = '0;
  endtask

  // Expected outputs for the current cycle, then advance the schedule by one cycle.
  task automatic model_cycle(output obs_t e);
    int own;
    own = m_slot % N;
    e = '0;
    if (m_ph == PH_SAMPLE) begin
      e.gnt[own] = req[own];
      p_live = req[own];
      p_id   = IDW'(own);
      p_data = req[own] ? in_data[own*W +: W] : '0;
    end
    if (m_ph == PH_EMIT) begin
      m_live = p_live; m_id = p_id; m_data = p_data;
    end
    e.valid = (m_ph == PH_EMIT);
    e.live  = m_live;
    e.id    = m_id;
    e.data  = m_data;
`ifdef CT_SCHED_SKIP_EN
    if (m_ph == PH_SAMPLE && !req[own]) begin
      m_slot++;
      m_ph = 0;
    end else begin
      m_ph++;
      if (m_ph == SL) begin m_ph = 0; m_slot++; end
    end
`else
    m_ph++;
    if (m_ph == SL) begin m_ph = 0; m_slot++; end
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    obs_t e, a;
    rst = 1'b1; req = 2'b11; in_data = {8'hA5, 8'h3C};
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = observed();
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL reset_hold got=%h want=%h", a, obs_t'(0));
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      model_cycle(e);
      a = observed();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset_after cyc=%0d got=%h want=%h", i, a, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single();
    obs_t e, a;
    do_reset();
    req = 2'b01; in_data = {8'h00, 8'h5A};
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      model_cycle(e);
      a = observed();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL single cyc=%0d got=%h want=%h", i, a, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_idle();
    obs_t e, a;
    do_reset();
    req = 2'b00;
    for (int i = 0; i < 16; i++) begin
      in_data = (N*W)'($urandom);
      @(negedge clk);
      model_cycle(e);
      a = observed();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL idle cyc=%0d got=%h want=%h", i, a, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    int last = -1;
    do_reset();
    req = 2'b11; in_data = {8'h22, 8'h11};
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      model_cycle(e);
      a = observed();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL b2b cyc=%0d got=%h want=%h", i, a, e);
      end
`ifndef CT_SCHED_SKIP_EN
      if (out_valid) begin
        if (last >= 0) begin
          checks++;
          if (i - last != SL) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d want=%0d", i - last, SL);
          end
        end
        last = i;
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_late_req();
    obs_t e, a;
    int ngnt = 0;
    do_reset();
    in_data = {8'hC3, 8'h96};
    for (int i = 0; i < 16; i++) begin
      req = (m_ph == PH_GATE && (m_slot % N) == 1) ? 2'b10 : 2'b00;
      @(negedge clk);
      model_cycle(e);
      a = observed();
      if (gnt != '0) ngnt++;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL late_req cyc=%0d got=%h want=%h", i, a, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ngnt != 0) begin
      errors++;
      $display("FAIL late_req_grants got=%0d want=0", ngnt);
    end
  endtask

  task automatic test_reset_mid_slot();
    obs_t e, a;
    do_reset();
    req = 2'b01; in_data = {8'h00, W'($urandom_range(1, 255))};
    @(negedge clk);
    model_cycle(e);
    a = observed();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL mid_rst_sample got=%h want=%h", a, e);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== '0) begin
      errors++;
      $display("FAIL mid_rst_gnt got=%b want=0", gnt);
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      model_cycle(e);
      a = observed();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL mid_rst cyc=%0d got=%h want=%h", i, a, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    obs_t e, a;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      req     = N'($urandom);
      in_data = (N*W)'($urandom);
      @(negedge clk);
      model_cycle(e);
      a = observed();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL random cyc=%0d req=%b got=%h want=%h", i, req, a, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; in_data = '0;
    model_reset();
    test_reset();
    test_single();
    test_idle();
    test_back_to_back();
    test_late_req();
    test_reset_mid_slot();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
